rr_frame_arbiter: RTL and testbench
===================================

Name: rr_frame_arbiter

Overview:
Round-robin arbiter that shares one fixed-length, multi-cycle resource frame among NREQ requesters. The resource is a 4-phase sequencer by default. Each grant owns the resource for exactly FRAME_LEN cycles, non-preemptive, and the block exposes the current phase count. It sits between requesting FSMs and the shared sequencer and emits a Mealy-style start strobe plus registered grant/phase outputs.

Parameters:
NREQ, 4, number of requesters (2..8)
FRAME_LEN, 4, cycles per granted frame (2..16)
IDW, 2, width of grant_id; must be >= ceil(log2(NREQ))
PW, 2, width of phase; must be >= ceil(log2(FRAME_LEN))

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NREQ  request vector, level-sensitive, held until served
grant  output  NREQ  one-hot grant, registered; all-zero when idle
grant_id  output  IDW  index of granted requester, registered; 0 when idle
phase  output  PW  cycle index within current frame (0..FRAME_LEN-1), registered
busy  output  1  high while a frame is in progress (state RUN)
start  output  1  Mealy strobe: (state==IDLE) & |req, combinational
done  output  1  busy & (phase==FRAME_LEN-1), combinational from registers

Behaviour:
- Reset (async, active-high, any time including mid-frame): state=IDLE, grant=0, grant_id=0, phase=0, ptr=0. busy=0 and done=0. start follows req immediately after reset deasserts.
- State IDLE:
  - if |req, pick winner w by round-robin search starting at ptr (ptr, ptr+1, ... wrapping mod NREQ; first set bit wins).
  - next edge: state=RUN, grant=1<<w, grant_id=w, phase=0, ptr=(w+1) mod NREQ.
  - if no req, stay IDLE; all outputs hold reset values.
- State RUN:
  - phase increments by 1 per cycle.
  - grant and grant_id are held constant for exactly FRAME_LEN cycles.
  - requests from other requesters are ignored until the last cycle.
- Last cycle (phase==FRAME_LEN-1, done=1):
  - if |req (any requester, including the current holder), re-arbitrate from ptr. Next edge: RUN, new grant, phase=0, ptr updated. This gives back-to-back frames with no idle gap.
  - else next edge: IDLE, grant=0, grant_id=0, phase=0.
- Latency: req asserted in IDLE at cycle k gives grant at cycle k+1. start=1 during cycle k only.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,...,NREQ-1,0,...
- Non-preemptive: a granted requester dropping req mid-frame does not shorten the frame (unless EARLY_RELEASE_EN).
- Simultaneous req edge and frame end: arbitration samples req in the done cycle.
- No illegal states: unused encodings return to IDLE on next edge.

Optional Feature:
Macro RR_FRAME_ARB_EARLY_RELEASE_EN.
- Defined: if the granted requester's req bit is 0 in any RUN cycle with phase < FRAME_LEN-1, that cycle is treated as the last cycle. done=1 that cycle and re-arbitration/IDLE follow as above.
- done definition becomes busy & ((phase==FRAME_LEN-1) | ~req[grant_id]).
- Undefined: frames are always exactly FRAME_LEN cycles.

Test Plan:
- Reset, req=0000 for 5 cycles -> grant=0000, busy=0, start=0, phase=0 throughout.
- Single request: req=0100 in IDLE -> start=1 that cycle; next cycle grant=0100, grant_id=2, phase 0,1,2,3 over 4 cycles, done=1 at phase 3. Drop req at phase 3 -> IDLE, grant=0000.
- All four requesters held (req=1111) -> back-to-back frames granting ids 0,1,2,3,0, each exactly 4 cycles, busy continuously 1, no IDLE cycle.
- Rotation check: after serving id 2, req=0101 at the done cycle -> next grant is id 0 (search 3,0). Then with req=0101 still held -> id 2.
- Reset asserted at phase 1 of a frame -> grant=0000, busy=0, phase=0 immediately (async). After release with req=0010 -> grant id 1 (ptr restarted at 0).
- With RR_FRAME_ARB_EARLY_RELEASE_EN: grant id 1, drop req[1] at phase 1 -> done=1 at phase 1. Next cycle IDLE, or a new grant if another req is pending. Without the macro, same stimulus -> frame runs to phase 3.

Source files
------------

// File: rtl/rr_frame_arbiter.sv
// Round-robin arbiter granting one fixed-length resource frame at a time to NREQ requesters.
// Optional macro RR_FRAME_ARB_EARLY_RELEASE_EN ends a frame early once the holder drops its request.
module rr_frame_arbiter #(
   parameter int NREQ      = 4,
   parameter int FRAME_LEN = 4,
   parameter int IDW       = 2,
   parameter int PW        = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic [PW-1:0]   phase,
   output logic            busy,
   output logic            start,
   output logic            done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1
   } state_t;

   localparam logic [NREQ-1:0] ONE_HOT0   = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]   LAST_PHASE = PW'(FRAME_LEN - 1);
   localparam logic [IDW-1:0]  LAST_ID    = IDW'(NREQ - 1);

   state_t          state_r, state_s;
   logic [NREQ-1:0] grant_r, grant_s;
   logic [IDW-1:0]  grant_id_r, id_s;
   logic [PW-1:0]   phase_r, phase_s;
   logic [IDW-1:0]  ptr_r, ptr_s;
   logic [IDW-1:0]  win_s;
   logic [IDW-1:0]  win_next_s;
   logic            any_req_s;
   logic            last_s;

   // First set request bit found searching upward from p, wrapping modulo NREQ.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
      logic [IDW-1:0] w;
      logic           found;
      int             idx;
      w     = {IDW{1'b0}};
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(p) + i) % NREQ;
         if (!found && r[idx]) begin
            w     = IDW'(idx);
            found = 1'b1;
         end
      end
      return w;
   endfunction

   assign any_req_s  = |req;
   assign win_s      = rr_pick(req, ptr_r);
   assign win_next_s = (win_s == LAST_ID) ? {IDW{1'b0}} : win_s + IDW'(1);

`ifdef RR_FRAME_ARB_EARLY_RELEASE_EN
   assign last_s = (phase_r == LAST_PHASE) | ~req[grant_id_r];
`else
   assign last_s = (phase_r == LAST_PHASE);
`endif

   assign busy     = (state_r == RUN);
   assign start    = (state_r == IDLE) & any_req_s;
   assign done     = busy & last_s;
   assign grant    = grant_r;
   assign grant_id = grant_id_r;
   assign phase    = phase_r;

   // Next-state: arbitrate from IDLE or at the final frame cycle, otherwise advance the phase.
   always_comb begin
      state_s = state_r;
      grant_s = grant_r;
      id_s    = grant_id_r;
      phase_s = phase_r;
      ptr_s   = ptr_r;
      case (state_r)
         IDLE, RUN: begin
            if ((state_r == IDLE) || done) begin
               if (any_req_s) begin
                  state_s = RUN;
                  grant_s = ONE_HOT0 << win_s;
                  id_s    = win_s;
                  phase_s = {PW{1'b0}};
                  ptr_s   = win_next_s;
               end else begin
                  state_s = IDLE;
                  grant_s = {NREQ{1'b0}};
                  id_s    = {IDW{1'b0}};
                  phase_s = {PW{1'b0}};
               end
            end else begin
               phase_s = phase_r + PW'(1);
            end
         end
         default: begin
            state_s = IDLE;
            grant_s = {NREQ{1'b0}};
            id_s    = {IDW{1'b0}};
            phase_s = {PW{1'b0}};
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         grant_r    <= {NREQ{1'b0}};
         grant_id_r <= {IDW{1'b0}};
         phase_r    <= {PW{1'b0}};
         ptr_r      <= {IDW{1'b0}};
      end else begin
         state_r    <= state_s;
         grant_r    <= grant_s;
         grant_id_r <= id_s;
         phase_r    <= phase_s;
         ptr_r      <= ptr_s;
      end
   end

endmodule

// File: tb/tb_rr_frame_arbiter.sv
// Table-driven bench for rr_frame_arbiter: each record is one cycle of req and expected outputs.
module tb_rr_frame_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic [1:0] phase;
   logic       busy, start, done;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] id;
      logic [1:0] phase;
      logic       busy;
      logic       start;
      logic       done;
   } vec_t;

   vec_t        vecs[$];
   logic [10:0] sb[$];
   int          checks = 0;
   int          errors = 0;
   int          vec_no = 0;

   rr_frame_arbiter #(.NREQ(4), .FRAME_LEN(4), .IDW(2), .PW(2)) dut (
      .clk(clk), .reset(reset), .req(req), .grant(grant), .grant_id(grant_id),
      .phase(phase), .busy(busy), .start(start), .done(done)
   );

   always #5 clk = ~clk;

   task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id,
                      input logic [1:0] ph, input logic b, input logic s, input logic d);
      vec_t v;
      v.req = r; v.grant = g; v.id = id; v.phase = ph;
      v.busy = b; v.start = s; v.done = d;
      vecs.push_back(v);
   endtask

   // One full frame: phases 0..2 with rmid, final phase with rlast.
   task automatic add_frame(input logic [3:0] rmid, input logic [3:0] rlast,
                            input logic [3:0] g, input logic [1:0] id);
      for (int p = 0; p < 3; p++) add(rmid, g, id, 2'(p), 1'b1, 1'b0, 1'b0);
      add(rlast, g, id, 2'd3, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {grant,id,phase,busy,start,done}=%b required %b", name, act, exp);
      end
   endtask

   task automatic run_vectors(input string tag);
      vec_t v;
      while (vecs.size() > 0) begin
         v = vecs.pop_front();
         @(posedge clk);
         #1 req = v.req;
         sb.push_back({v.grant, v.id, v.phase, v.busy, v.start, v.done});
         @(negedge clk);
         check($sformatf("%s[%0d]", tag, vec_no),
               {grant, grant_id, phase, busy, start, done}, sb.pop_front());
         vec_no++;
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b0000;
      #1 check("reset_state", {grant, grant_id, phase, busy, start, done}, 11'b0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      // Idle after reset, then all four requesters rotate back-to-back from ptr 0.
      for (int i = 0; i < 5; i++) add(4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      add(4'b1111, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      add_frame(4'b1111, 4'b1111, 4'b0001, 2'd0);
      add_frame(4'b1111, 4'b1111, 4'b0010, 2'd1);
      add_frame(4'b1111, 4'b1111, 4'b0100, 2'd2);
      add_frame(4'b1111, 4'b1111, 4'b1000, 2'd3);
      add_frame(4'b1111, 4'b0000, 4'b0001, 2'd0);
      add(4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      // ptr=1: single request for id 2, then 0101 at done gives id 0, then id 2.
      add(4'b0100, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      add_frame(4'b0100, 4'b0101, 4'b0100, 2'd2);
      add_frame(4'b0101, 4'b0101, 4'b0001, 2'd0);
      add_frame(4'b0101, 4'b0000, 4'b0100, 2'd2);
      add(4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      // ptr=3: request id 0 and run into phase 1.
      add(4'b0001, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      add(4'b0001, 4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      add(4'b0001, 4'b0001, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
      run_vectors("seq");

      // Asynchronous reset mid-frame takes effect without a clock edge.
      #1 reset = 1'b1;
      req = 4'b0000;
      #1 check("async_reset", {grant, grant_id, phase, busy, start, done}, 11'b0);
      @(posedge clk);
      #2 reset = 1'b0;

      // ptr restarted at 0: req 0010 wins id 1; id 1 drops its request at phase 1.
      add(4'b0010, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
      add(4'b0010, 4'b0010, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
`ifdef RR_FRAME_ARB_EARLY_RELEASE_EN
      add(4'b1000, 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1);
`else
      add(4'b1000, 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
      add(4'b1000, 4'b0010, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
      add(4'b1000, 4'b0010, 2'd1, 2'd3, 1'b1, 1'b0, 1'b1);
`endif
      add_frame(4'b1000, 4'b0000, 4'b1000, 2'd3);
      add(4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      run_vectors("post_reset");

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
